// File: rtl/gmii_tx_arbiter.sv
// Per-frame arbiter sharing one GMII TX path among NUM_CH UDP engines.
// Latency: request -> start pulse/grant 2 cycles; engine byte -> gmii_txd 1 cycle.
// Backpressure: none on GMII; each channel queues one pending frame until granted.
module gmii_tx_arbiter #(
    parameter int NUM_CH        = 2,
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                  gmii_tx_clk,
    input  logic                  rst_n,
    input  logic                  prio_mode,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     req_start_en,
    output logic [NUM_CH-1:0]     req_pending,
    output logic [NUM_CH-1:0]     eng_tx_start_en,
    input  logic [NUM_CH-1:0]     eng_tx_en,
    input  logic [NUM_CH*8-1:0]   eng_txd,
    output logic [NUM_CH-1:0]     grant,
    output logic                  gmii_tx_en,
    output logic [7:0]            gmii_txd,
    output logic [NUM_CH-1:0]     ch_tx_done,
    output logic [NUM_CH-1:0]     timeout_err
);
    localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CMAX = (START_TIMEOUT > IFG_CYCLES) ? START_TIMEOUT : IFG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_SOF, FRAME, GAP} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] cand;
    logic [IW-1:0]     last_idx;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     lo_idx;
    logic [IW-1:0]     hi_idx;
    logic              hi_found;
    logic [CW-1:0]     cnt;
    logic              g_tx_en;
    logic [7:0]        g_txd;
    logic              fwd;

    assign cand        = pend & ch_enable;
    assign req_pending = pend;

    // lo_idx: lowest candidate; hi_idx: lowest candidate above the last owner
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_idx = IW'(i);
                if (i > int'(last_idx)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        sel_idx = (prio_mode || !hi_found) ? lo_idx : hi_idx;
    end

    always_comb begin
        g_txd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) g_txd = g_txd | eng_txd[8*i +: 8];
        end
    end

    assign g_tx_en = |(eng_tx_en & grant);
    assign fwd     = ((state == WAIT_SOF) || (state == FRAME)) && g_tx_en;

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        eng_tx_start_en = '0;
        ch_tx_done      = '0;
        timeout_err     = '0;
        case (state)
            IDLE:     if (|cand) state_nxt = START;
            START: begin
                eng_tx_start_en = grant;
                state_nxt       = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (g_tx_en) begin
                    state_nxt = FRAME;
                end else if (cnt == CW'(START_TIMEOUT)) begin
                    timeout_err = grant;
                    state_nxt   = GAP;
                end
            end
            FRAME: begin
                if (!g_tx_en) begin
                    ch_tx_done = grant;
                    state_nxt  = GAP;
                end
            end
            GAP:      if (cnt == CW'(IFG_CYCLES - 1)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // cnt is 0 in START and counts through WAIT_SOF; it restarts on GAP entry
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            grant    <= '0;
            last_idx <= IW'(NUM_CH - 1);
            cnt      <= '0;
        end else begin
            pend <= (pend & ~eng_tx_start_en) | req_start_en;
            if (state == IDLE && |cand) begin
                grant    <= NUM_CH'(1) << sel_idx;
                last_idx <= sel_idx;
            end else if (state_nxt == GAP && state != GAP) begin
                grant <= '0;
            end
            if (state == IDLE || (state_nxt == GAP && state != GAP)) cnt <= '0;
            else if (state != FRAME)                                 cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
        end else begin
            gmii_tx_en <= fwd;
            gmii_txd   <= fwd ? g_txd : 8'h00;
        end
    end
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: two channels, IFG 12, start timeout 16.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;
    localparam int NCH = 2;

    logic        clk;
    logic        rst_n;
    logic        prio_mode;
    logic [1:0]  ch_enable;
    logic [1:0]  req_start_en;
    logic [1:0]  req_pending;
    logic [1:0]  eng_tx_start_en;
    logic [1:0]  eng_tx_en;
    logic [15:0] eng_txd;
    logic [1:0]  grant;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic [1:0]  ch_tx_done;
    logic [1:0]  timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [1:0] mute;
    logic [1:0] stray;
    int         flen[2];
    logic [7:0] base[2];
    logic       busy[2];
    int         pos[2];

    int         cyc = 0;
    int         clr_gen = 0;
    int         seen_gen = 0;
    logic [7:0] rx_q[$];
    int         frm_len[$];
    int         rise_cyc[$];
    int         start_ch[$];
    int         start_cyc[$];
    int         done_ch[$];
    int         done_cyc[$];
    int         to_ch[$];
    int         to_cyc[$];
    int         min_gap;
    int         cur_len;
    int         fall_cyc;
    int         idle_nz;
    logic       prev_en;
    logic       have_fall;

    gmii_tx_arbiter #(.NUM_CH(2), .IFG_CYCLES(12), .START_TIMEOUT(16)) dut (
        .gmii_tx_clk     (clk),
        .rst_n           (rst_n),
        .prio_mode       (prio_mode),
        .ch_enable       (ch_enable),
        .req_start_en    (req_start_en),
        .req_pending     (req_pending),
        .eng_tx_start_en (eng_tx_start_en),
        .eng_tx_en       (eng_tx_en),
        .eng_txd         (eng_txd),
        .grant           (grant),
        .gmii_tx_en      (gmii_tx_en),
        .gmii_txd        (gmii_txd),
        .ch_tx_done      (ch_tx_done),
        .timeout_err     (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: drives at edge+1, starts its frame the cycle after its start pulse
    initial begin
        eng_tx_en = '0;
        eng_txd   = '0;
        busy[0] = 1'b0; busy[1] = 1'b0;
        pos[0] = 0;     pos[1] = 0;
        forever begin
            @(posedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                if (busy[c] && pos[c] < flen[c]) begin
                    eng_tx_en[c]      = 1'b1;
                    eng_txd[c*8 +: 8] = base[c] + 8'(pos[c]);
                    pos[c]++;
                end else begin
                    busy[c]           = 1'b0;
                    eng_tx_en[c]      = stray[c];
                    eng_txd[c*8 +: 8] = stray[c] ? 8'hEE : 8'h00;
                end
                if (eng_tx_start_en[c] && !mute[c]) begin
                    busy[c] = 1'b1;
                    pos[c]  = 0;
                end
            end
        end
    end

    // Monitor: samples at edge+2 and logs bytes, frames, gaps and pulses
    initial begin
        prev_en = 1'b0; have_fall = 1'b0; min_gap = 1000000;
        cur_len = 0; fall_cyc = 0; idle_nz = 0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                rx_q.delete(); frm_len.delete(); rise_cyc.delete();
                start_ch.delete(); start_cyc.delete(); done_ch.delete(); done_cyc.delete();
                to_ch.delete(); to_cyc.delete();
                min_gap = 1000000; have_fall = 1'b0; idle_nz = 0;
            end
            if (gmii_tx_en === 1'b1) begin
                rx_q.push_back(gmii_txd);
                cur_len++;
                if (!prev_en) begin
                    rise_cyc.push_back(cyc);
                    if (have_fall && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
                end
                prev_en = 1'b1;
            end else begin
                if (gmii_txd !== 8'h00) idle_nz++;
                if (prev_en) begin
                    frm_len.push_back(cur_len);
                    cur_len = 0; fall_cyc = cyc; have_fall = 1'b1;
                end
                prev_en = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (eng_tx_start_en[c] === 1'b1) begin start_ch.push_back(c); start_cyc.push_back(cyc); end
                if (ch_tx_done[c] === 1'b1)      begin done_ch.push_back(c);  done_cyc.push_back(cyc);  end
                if (timeout_err[c] === 1'b1)     begin to_ch.push_back(c);    to_cyc.push_back(cyc);    end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #3;
        end
    endtask

    task automatic clear_logs();
        clr_gen++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_start_en = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_req(input logic [1:0] r);
        req_start_en = r;
        tick(1);
        req_start_en = '0;
    endtask

    task automatic test_reset();
        stray = 2'b11;
        rst_n = 1'b0;
        tick(2);
        total_cnt++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) $display("FAIL reset_gmii: en=%b txd=%h want 0/00", gmii_tx_en, gmii_txd);
        else pass_cnt++;
        total_cnt++;
        if (grant !== 2'b00 || eng_tx_start_en !== 2'b00) $display("FAIL reset_grant: grant=%b start=%b want 00/00", grant, eng_tx_start_en);
        else pass_cnt++;
        total_cnt++;
        if (req_pending !== 2'b00 || ch_tx_done !== 2'b00 || timeout_err !== 2'b00)
            $display("FAIL reset_flags: pend=%b done=%b to=%b want 00", req_pending, ch_tx_done, timeout_err);
        else pass_cnt++;
        rst_n = 1'b1;
        clear_logs();
        tick(10);
        total_cnt++;
        if (rx_q.size() != 0 || start_ch.size() != 0) $display("FAIL reset_stray: bytes=%0d starts=%0d want 0/0", rx_q.size(), start_ch.size());
        else pass_cnt++;
        stray = 2'b00;
        tick(2);
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        prio_mode = 1'b0; ch_enable = 2'b11; flen[0] = 64;
        clear_logs();
        pulse_req(2'b01);
        total_cnt++;
        if (req_pending !== 2'b01) $display("FAIL single_pending: got %b want 01", req_pending);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (eng_tx_start_en !== 2'b01 || grant !== 2'b01) $display("FAIL single_start: start=%b grant=%b want 01/01", eng_tx_start_en, grant);
        else pass_cnt++;
        tick(90);
        total_cnt++;
        if (start_ch.size() != 1 || rise_cyc.size() != 1 || rise_cyc[0] - start_cyc[0] != 2)
            $display("FAIL single_latency: starts=%0d rises=%0d want 1/1 with byte 2 cycles after start", start_ch.size(), rise_cyc.size());
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'(k)) bad++;
        total_cnt++;
        if (rx_q.size() != 64 || bad != 0) $display("FAIL single_bytes: count=%0d bad=%0d want 64/0", rx_q.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (done_ch.size() != 1 || done_ch[0] != 0 || done_cyc[0] - start_cyc[0] != 65)
            $display("FAIL single_done: pulses=%0d want one on ch0 65 cycles after start", done_ch.size());
        else pass_cnt++;
        total_cnt++;
        if (idle_nz != 0 || grant !== 2'b00) $display("FAIL single_idle: idle_nz=%0d grant=%b want 0/00", idle_nz, grant);
        else pass_cnt++;
    endtask

    task automatic test_rr();
        int bad;
        logic [7:0] exp_b;
        apply_reset();
        prio_mode = 1'b0; ch_enable = 2'b11; flen[0] = 60; flen[1] = 60;
        clear_logs();
        pulse_req(2'b11);
        total_cnt++;
        if (req_pending !== 2'b11) $display("FAIL rr_pending: got %b want 11", req_pending);
        else pass_cnt++;
        tick(170);
        pulse_req(2'b11);
        tick(170);
        total_cnt++;
        if (start_ch.size() != 4 || start_ch[0] != 0 || start_ch[1] != 1 || start_ch[2] != 0 || start_ch[3] != 1)
            $display("FAIL rr_order: starts=%0d want order 0,1,0,1", start_ch.size());
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++) begin
            exp_b = (((k / 60) % 2) == 1) ? 8'h80 : 8'h00;
            exp_b = exp_b + 8'(k % 60);
            if (rx_q[k] !== exp_b) bad++;
        end
        total_cnt++;
        if (rx_q.size() != 240 || frm_len.size() != 4 || bad != 0)
            $display("FAIL rr_bytes: bytes=%0d frames=%0d bad=%0d want 240/4/0", rx_q.size(), frm_len.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (min_gap < 12 || done_ch.size() != 4) $display("FAIL rr_gap: min_gap=%0d dones=%0d want >=12/4", min_gap, done_ch.size());
        else pass_cnt++;
    endtask

    task automatic test_prio();
        int bad;
        apply_reset();
        prio_mode = 1'b1; ch_enable = 2'b11; flen[0] = 60; flen[1] = 60;
        clear_logs();
        pulse_req(2'b10);
        tick(12);
        ch_enable = 2'b01;
        pulse_req(2'b01);
        total_cnt++;
        if (grant !== 2'b10) $display("FAIL prio_owner: grant=%b want 10", grant);
        else pass_cnt++;
        tick(170);
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++)
            if (rx_q[k] !== ((k < 60) ? 8'h80 + 8'(k) : 8'(k - 60))) bad++;
        total_cnt++;
        if (start_ch.size() != 2 || start_ch[0] != 1 || start_ch[1] != 0 || rx_q.size() != 120 || bad != 0)
            $display("FAIL prio_late: starts=%0d bytes=%0d bad=%0d want ch1 then ch0, 120/0", start_ch.size(), rx_q.size(), bad);
        else pass_cnt++;
        ch_enable = 2'b11;
        clear_logs();
        pulse_req(2'b11);
        tick(170);
        total_cnt++;
        if (start_ch.size() != 2 || start_ch[0] != 0 || start_ch[1] != 1)
            $display("FAIL prio_fixed: starts=%0d want order 0,1", start_ch.size());
        else pass_cnt++;
        ch_enable = 2'b10;
        clear_logs();
        pulse_req(2'b01);
        tick(40);
        total_cnt++;
        if (start_ch.size() != 0 || req_pending !== 2'b01) $display("FAIL prio_mask: starts=%0d pend=%b want 0/01", start_ch.size(), req_pending);
        else pass_cnt++;
        pulse_req(2'b10);
        tick(90);
        total_cnt++;
        if (start_ch.size() != 1 || start_ch[0] != 1 || req_pending !== 2'b01 || frm_len.size() != 1)
            $display("FAIL prio_mask_other: starts=%0d pend=%b frames=%0d want ch1 only/01/1", start_ch.size(), req_pending, frm_len.size());
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        prio_mode = 1'b0; ch_enable = 2'b11; mute = 2'b01; flen[1] = 60;
        clear_logs();
        pulse_req(2'b11);
        tick(20);
        total_cnt++;
        if (to_ch.size() != 1 || to_ch[0] != 0 || to_cyc[0] - start_cyc[0] != 16)
            $display("FAIL timeout_pulse: pulses=%0d want one on ch0 16 cycles after start", to_ch.size());
        else pass_cnt++;
        stray = 2'b01;
        tick(120);
        stray = 2'b00;
        bad = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'h80 + 8'(k)) bad++;
        total_cnt++;
        if (start_ch.size() != 2 || start_ch[1] != 1 || done_ch.size() != 1 || done_ch[0] != 1)
            $display("FAIL timeout_next: starts=%0d dones=%0d want 2 starts, one done on ch1", start_ch.size(), done_ch.size());
        else pass_cnt++;
        total_cnt++;
        if (rx_q.size() != 60 || bad != 0 || req_pending !== 2'b00)
            $display("FAIL timeout_bytes: bytes=%0d bad=%0d pend=%b want 60/0/00", rx_q.size(), bad, req_pending);
        else pass_cnt++;
        mute = 2'b00;
    endtask

    task automatic test_reset_mid();
        int n0;
        apply_reset();
        prio_mode = 1'b0; ch_enable = 2'b11; flen[0] = 64;
        clear_logs();
        pulse_req(2'b01);
        tick(5);
        pulse_req(2'b10);
        total_cnt++;
        if (req_pending !== 2'b10) $display("FAIL mid_pending: got %b want 10", req_pending);
        else pass_cnt++;
        for (int k = 0; k < 80 && rx_q.size() < 30; k++) tick(1);
        total_cnt++;
        if (rx_q.size() != 30) $display("FAIL mid_reach30: bytes=%0d want 30", rx_q.size());
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || grant !== 2'b00 || req_pending !== 2'b00)
            $display("FAIL mid_async: en=%b txd=%h grant=%b pend=%b want 0/00/00/00", gmii_tx_en, gmii_txd, grant, req_pending);
        else pass_cnt++;
        tick(2);
        rst_n = 1'b1;
        n0 = rx_q.size();
        tick(60);
        total_cnt++;
        if (rx_q.size() != n0 || start_ch.size() != 1 || req_pending !== 2'b00)
            $display("FAIL mid_after: bytes=%0d starts=%0d pend=%b want %0d/1/00", rx_q.size(), start_ch.size(), req_pending, n0);
        else pass_cnt++;
        pulse_req(2'b01);
        tick(80);
        total_cnt++;
        if (start_ch.size() != 2 || frm_len.size() != 2 || frm_len[1] != 64)
            $display("FAIL mid_regrant: starts=%0d frames=%0d want 2/2 with 64-byte frame", start_ch.size(), frm_len.size());
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; prio_mode = 1'b0; ch_enable = 2'b11; req_start_en = '0;
        mute = '0; stray = '0;
        flen[0] = 64; flen[1] = 64;
        base[0] = 8'h00; base[1] = 8'h80;
        test_reset();
        test_single();
        test_rr();
        test_prio();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
